// File: rtl/ws2812_strip_driver.sv
// WS2812-class LED chain driver: takes a frame of pixels over valid/ready and
// sends each pixel MSB-first with cycle-exact high times, then closes with a latch period.
module ws2812_strip_driver #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BIT_HZ       = 800_000,
    parameter int T0H_NS       = 400,
    parameter int T1H_NS       = 800,
    parameter int RESET_US     = 50,
    parameter int NUM_LEDS     = 16,
    parameter int BITS_PER_LED = 24,
    localparam int IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                    i_clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [BITS_PER_LED-1:0] i_pix_data,
    input  logic                    i_pix_valid,
    output logic                    o_pix_ready,
    output logic                    o_dout,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_underrun,
    output logic [IDX_W-1:0]        o_led_index
);

    localparam int BIT_CYC   = CLK_HZ / BIT_HZ;
    localparam int T0H_CYC   = (CLK_HZ / 1_000_000) * T0H_NS / 1000;
    localparam int T1H_CYC   = (CLK_HZ / 1_000_000) * T1H_NS / 1000;
    localparam int RESET_CYC = (CLK_HZ / 1_000_000) * RESET_US;
    localparam int CYC_W     = $clog2(BIT_CYC + 1);
    localparam int LAT_W     = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
    localparam int BIT_W     = $clog2(BITS_PER_LED);
    localparam int ACC_W     = $clog2(NUM_LEDS + 1);

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] T0H       = CYC_W'(T0H_CYC);
    localparam logic [CYC_W-1:0] T1H       = CYC_W'(T1H_CYC);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RESET_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS_PER_LED - 1);
    localparam logic [IDX_W-1:0] LED_LAST  = IDX_W'(NUM_LEDS - 1);
    localparam logic [ACC_W-1:0] NUM_ACC   = ACC_W'(NUM_LEDS);

    if (BITS_PER_LED != 24 && BITS_PER_LED != 32) begin : g_bad_bpl
        $error("BITS_PER_LED must be 24 or 32");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_BIT,
        S_LATCH
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [BITS_PER_LED-1:0] r_shadow;
    logic [BITS_PER_LED-1:0] r_shift;
    logic                    r_shadow_full;
    logic [CYC_W-1:0]        r_cyc_cnt;
    logic [BIT_W-1:0]        r_bit_idx;
    logic [LAT_W-1:0]        r_latch_cnt;
    logic [IDX_W-1:0]        r_led_index;
    logic [ACC_W-1:0]        r_accepted;
    logic                    r_frame_ok;
    logic                    r_dout;
    logic                    r_frame_done;
    logic                    r_underrun;

    logic [CYC_W-1:0]        w_th;
    logic                    w_xfer;
    logic                    w_frame_start;
    logic                    w_load_shift;
    logic                    w_shift;
    logic                    w_complete;
    logic                    w_abort;
    logic                    w_latch_end;
    logic                    w_dout_next;

    assign w_th        = r_shift[BITS_PER_LED-1] ? T1H : T0H;
    assign o_pix_ready = !r_shadow_full
                         && (r_state == S_WAIT_FIRST || r_state == S_BIT)
                         && (r_accepted < NUM_ACC);
    assign w_xfer      = i_pix_valid && o_pix_ready;

    assign o_dout       = r_dout;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;
    assign o_underrun   = r_underrun;
    assign o_led_index  = r_led_index;

    always_ff @(posedge i_clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_LATCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_load_shift  = 1'b0;
        w_shift       = 1'b0;
        w_complete    = 1'b0;
        w_abort       = 1'b0;
        w_latch_end   = 1'b0;
        w_dout_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_frame_start = 1'b1;
                    w_state_next  = S_WAIT_FIRST;
                end
            end
            S_WAIT_FIRST: begin
                if (r_shadow_full) begin
                    w_load_shift = 1'b1;
                    w_state_next = S_BIT;
                end
            end
            S_BIT: begin
                w_dout_next = (r_cyc_cnt < w_th);
                // End of a bit period: next bit, next pixel, clean finish or underrun.
                if (r_cyc_cnt == CYC_LAST) begin
                    if (r_bit_idx != BIT_LAST) begin
                        w_shift = 1'b1;
                    end else if (r_led_index == LED_LAST) begin
                        w_complete   = 1'b1;
                        w_state_next = S_LATCH;
                    end else if (r_shadow_full) begin
                        w_load_shift = 1'b1;
                    end else begin
                        w_abort      = 1'b1;
                        w_state_next = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                if (r_latch_cnt == LAT_LAST) begin
                    w_latch_end  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_LATCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge rst_n) begin
        if (rst_n) begin
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_cyc_cnt     <= '0;
            r_latch_cnt   <= '0;
            r_led_index   <= '0;
            r_accepted    <= '0;
            r_frame_ok    <= 1'b0;
            r_dout        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_dout       <= w_dout_next;
            r_underrun   <= w_abort;
            r_frame_done <= w_latch_end && r_frame_ok;

            if (w_latch_end || w_frame_start) begin
                r_frame_ok <= 1'b0;
            end else if (w_complete) begin
                r_frame_ok <= 1'b1;
            end

            // An abort wins over a same-cycle transfer so nothing leaks into the next frame.
            if (w_abort) begin
                r_shadow_full <= 1'b0;
            end else if (w_xfer) begin
                r_shadow      <= i_pix_data;
                r_shadow_full <= 1'b1;
            end else if (w_load_shift) begin
                r_shadow_full <= 1'b0;
            end

            if (w_frame_start) begin
                r_accepted <= '0;
            end else if (w_xfer && !w_abort) begin
                r_accepted <= r_accepted + 1'b1;
            end

            if (w_load_shift) begin
                r_shift   <= r_shadow;
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_shift   <= r_shift << 1;
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            if (r_state == S_BIT && r_cyc_cnt != CYC_LAST) begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            end else begin
                r_cyc_cnt <= '0;
            end

            if (r_state == S_LATCH) begin
                r_latch_cnt <= r_latch_cnt + 1'b1;
            end else begin
                r_latch_cnt <= '0;
            end

            if (w_frame_start || w_complete || w_abort) begin
                r_led_index <= '0;
            end else if (w_load_shift && r_state == S_BIT) begin
                r_led_index <= r_led_index + 1'b1;
            end
        end
    end

endmodule

// File: doc/ws2812_strip_driver.md
Name: ws2812_strip_driver

Overview:
Parametrised serial driver for WS2812-class addressable LED chains. It accepts a frame of NUM_LEDS pixels over a valid/ready stream and shifts each pixel out MSB-first on one data line with cycle-exact T0H/T1H timing. It closes every frame, and every abort, with a latch (reset-low) period. It supersedes the fixed 16-LED, fixed-timing, 24-bit-only strip driver, and adds RGBW (32-bit) support, start/busy/done control, and underrun detection.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BIT_HZ, 800_000, line bit rate; BIT_CYC = CLK_HZ/BIT_HZ (125 at defaults)
T0H_NS, 400, high time of a 0 bit; T0H_CYC = (CLK_HZ/1_000_000)*T0H_NS/1000 (40)
T1H_NS, 800, high time of a 1 bit; T1H_CYC computed the same way (80)
RESET_US, 50, latch low time; RESET_CYC = (CLK_HZ/1_000_000)*RESET_US (5000)
NUM_LEDS, 16, pixels per frame, 1..1024
BITS_PER_LED, 24, bits per pixel, 24 (GRB) or 32 (GRBW); other values are illegal
IDX_W, $clog2(NUM_LEDS) minimum 1 (localparam), width of o_led_index

Ports:
i_clk  in  1  system clock, all logic on its rising edge
rst_n  in  1  reset, asynchronous, active-high despite the name
i_start  in  1  single-cycle frame start request; honoured only in IDLE
i_pix_data  in  BITS_PER_LED  pixel word, first colour byte in the MSBs, sent MSB-first
i_pix_valid  in  1  pixel word valid
o_pix_ready  out  1  driver can accept a pixel this cycle
o_dout  out  1  registered serial line to the LED chain
o_busy  out  1  high in every state except IDLE
o_frame_done  out  1  one-cycle pulse when the latch after a complete frame ends
o_underrun  out  1  one-cycle pulse when a frame is aborted for missing data
o_led_index  out  IDX_W  index of the pixel currently shifting; 0 outside a frame

Behaviour:
- Async reset values: o_dout=0, o_pix_ready=0, o_frame_done=0, o_underrun=0, o_led_index=0, shadow buffer empty, state=LATCH, latch counter=0. o_busy is 1 (state is LATCH).
- After reset release the block runs one full RESET_CYC latch period, then enters IDLE. It does not pulse o_frame_done on this latch.
- States:
  - IDLE: o_dout=0. i_start=1 moves to WAIT_FIRST.
  - WAIT_FIRST: line stays low; waits indefinitely for the first pixel.
  - BIT: drives the current bit.
  - LATCH: holds the line low for RESET_CYC cycles.
- Buffering: one shadow register plus a BITS_PER_LED shift register. o_pix_ready = shadow empty AND state in {WAIT_FIRST, BIT} AND pixels accepted this frame < NUM_LEDS. A transfer occurs when valid and ready are both high. The first pixel goes from shadow to the shift register on the cycle after acceptance, and the state then moves to BIT.
- BIT timing: the bit counter runs 0..BIT_CYC-1. o_dout=1 for counts 0..TH-1 and 0 for the rest, where TH = T1H_CYC if shift MSB=1, else T0H_CYC. The high time is exactly TH cycles; the period is exactly BIT_CYC cycles, with no gap cycles between bits or between pixels.
- At count BIT_CYC-1:
  - If this is not the last bit: shift left and increment the bit count.
  - If it is the last bit and o_led_index=NUM_LEDS-1: go to LATCH with the frame-complete flag set.
  - If it is the last bit, more pixels remain and the shadow is full: load the shadow into the shift register, increment o_led_index, and continue BIT at the next cycle.
  - If it is the last bit, more pixels remain and the shadow is empty: pulse o_underrun, go to LATCH with the flag clear, and discard the rest of the frame.
- LATCH: on completion, pulse o_frame_done if the flag is set, then go to IDLE. o_busy falls in the same cycle o_frame_done pulses.
- i_start is ignored outside IDLE. This includes the cycle LATCH completes; there is no queuing.
- i_pix_valid is ignored when o_pix_ready=0. Data already in the shadow at an abort is discarded.
- Reset asserted mid-frame: o_dout goes to 0 immediately (asynchronously), and the full latch period is re-applied after release.

Test Plan:
1. Defaults with NUM_LEDS=2, valid held high, pixels 24'hFF00A5 then 24'h000001 -> exactly 48 periods of 125 cycles. Bits 0-7 are 80 cycles high; bits 8-15 are 40 high; bits 16-23 follow A5. The last bit is 80 high. Then 5000 low cycles, o_frame_done pulses once, o_busy drops, and o_led_index reads 0,1,0.
2. NUM_LEDS=3 with valid dropped after pixel 1 -> the line sends 2 pixels (48 bits). o_underrun pulses at the end of bit 47, the line stays low for 5000 cycles, there is no o_frame_done pulse, and the block returns to IDLE.
3. First pixel valid delayed 300 cycles after i_start -> o_dout stays 0 throughout, and the first rising edge occurs 2 cycles after the transfer.
4. i_start pulsed while in BIT and on the LATCH-completion cycle -> both are ignored: no second frame, and o_busy is 0 after the latch.
5. rst_n pulsed at bit 10, count 20 -> o_dout is 0 immediately. After release: 5000 low cycles, IDLE, and no o_frame_done or o_underrun pulse.
6. BITS_PER_LED=32, NUM_LEDS=1, pixel 32'h80000001 -> 32 bits; the first and last are 80 high, the others 40 high. Then latch and o_frame_done.
